// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable clock-enable generator.
// From clk_in it derives a one-cycle tick strobe and a near-50% square wave
// div_frec, both at clk_in/N. A new N can be loaded at run time. It is held
// pending and takes effect only at a period boundary, so no period is
// truncated or stretched.
module clk_div_prog #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 50000
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  output logic             div_pending,
  output logic             tick,
  output logic             div_frec
);

  localparam logic [WIDTH-1:0] LP_DEFAULT_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] LP_ONE         = WIDTH'(1);
  localparam logic [WIDTH-1:0] LP_TWO         = WIDTH'(2);

  logic [WIDTH-1:0] r_active_div;
  logic [WIDTH-1:0] r_pending_div;
  logic             r_pending;
  logic [WIDTH-1:0] r_count;
  logic             r_tick;
  logic             r_frec;

  logic             w_run;
  logic             w_last;
  logic             w_wrap;
  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH-1:0] w_low_len;
  logic             w_frec_next;

  // Divisors 0 and 1 do not count: 0 stops the divider, 1 passes en through.
  assign w_run        = (r_active_div >= LP_TWO);
  assign w_last       = (r_count == (r_active_div - LP_ONE));
  assign w_wrap       = en & w_last & w_run;
  assign w_count_next = w_wrap ? '0 : (r_count + LP_ONE);
  // The low phase gets the extra cycle for odd N: L = N - floor(N/2).
  assign w_low_len    = r_active_div - (r_active_div >> 1);
  assign w_frec_next  = (w_count_next >= w_low_len);

  // Divisor load/apply: a load coinciding with a boundary is applied directly;
  // otherwise it waits in pending_div (last load wins) until the next boundary.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_active_div <= LP_DEFAULT_DIV;
      r_pending    <= 1'b0;
    end else if (div_load && (w_wrap || sync_clr)) begin
      r_active_div <= div_value;
      r_pending    <= 1'b0;
    end else if (div_load) begin
      r_pending_div <= div_value;
      r_pending     <= 1'b1;
    end else if (r_pending && (w_wrap || sync_clr || !w_run)) begin
      r_active_div <= r_pending_div;
      r_pending    <= 1'b0;
    end
  end

  // Period counter with registered tick and square-wave outputs.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_count <= '0;
      r_tick  <= 1'b0;
      r_frec  <= 1'b0;
    end else if (sync_clr) begin
      r_count <= '0;
      r_tick  <= 1'b0;
      r_frec  <= 1'b0;
    end else if (!w_run) begin
      r_count <= '0;
      r_tick  <= en & (r_active_div == LP_ONE);
      r_frec  <= 1'b0;
    end else if (en) begin
      r_count <= w_count_next;
      r_tick  <= w_wrap;
      r_frec  <= w_frec_next;
    end else begin
      r_tick  <= 1'b0;
    end
  end

  assign div_pending = r_pending;
  assign tick        = r_tick;
  assign div_frec    = r_frec;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog with WIDTH=8, DEFAULT_DIV=8.
// Each run() call applies one clock edge per character of its pattern strings
// and compares tick, div_frec and div_pending against the hand-written
// expected sequences (first character = first edge).
module tb_clk_div_prog;

  logic       clk_in;
  logic       reset;
  logic       en;
  logic       sync_clr;
  logic       div_load;
  logic [7:0] div_value;
  logic       div_pending;
  logic       tick;
  logic       div_frec;

  int nvec = 0;
  int nerr = 0;

  clk_div_prog #(
    .WIDTH      (8),
    .DEFAULT_DIV(8)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .en         (en),
    .sync_clr   (sync_clr),
    .div_load   (div_load),
    .div_value  (div_value),
    .div_pending(div_pending),
    .tick       (tick),
    .div_frec   (div_frec)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input int idx, input string sig,
                     input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s[%0d] %s observed=%b expected=%b", tag, idx, sig, obs, exp);
    end
  endtask

  task automatic run(input string tag, input string t, input string f, input string p);
    for (int i = 0; i < t.len(); i++) begin
      @(posedge clk_in);
      #1;
      chk(tag, i, "tick",        tick,        t[i] == "1");
      chk(tag, i, "div_frec",    div_frec,    f[i] == "1");
      chk(tag, i, "div_pending", div_pending, p[i] == "1");
    end
  endtask

  initial begin
    reset     = 1'b1;
    en        = 1'b1;
    sync_clr  = 1'b0;
    div_load  = 1'b0;
    div_value = 8'd0;

    // Outputs stay zero while reset is held, even with en high.
    run("rst", "000", "000", "000");
    reset = 1'b0;

    // Default N=8: tick on edges 8,16,24; div_frec 4 low, 4 high.
    run("div8", "00000001000000010000000100",
                "00011110000111100001111000",
                "00000000000000000000000000");

    // Load 5 at count=2; pending until the wrap from count 7.
    div_load = 1'b1; div_value = 8'd5;
    run("ld5_cap", "0", "0", "1");
    div_load = 1'b0;
    run("ld5_wait", "00001", "11110", "11110");
    run("div5", "0000100001", "0011000110", "0000000000");

    // Load 3 exactly on the wrap edge: applied at once, never pending.
    run("w3_pre", "0000", "0011", "0000");
    div_load = 1'b1; div_value = 8'd3;
    run("w3_load", "1", "0", "0");
    div_load = 1'b0;
    run("div3", "001001", "010010", "000000");

    // Back to N=8 through a normal pending load, then run up to count=4.
    div_load = 1'b1; div_value = 8'd8;
    run("ld8_cap", "0", "0", "1");
    div_load = 1'b0;
    run("ld8_wrap", "01", "10", "10");
    run("pre_hold", "0000", "0001", "0000");

    // en low for 10 cycles at count=4: frozen with div_frec high, no tick.
    en = 1'b0;
    run("hold", "0000000000", "1111111111", "0000000000");
    en = 1'b1;
    run("resume", "0001", "1110", "0000");

    // Pending 12, then sync_clr at count=6 restarts with N=12.
    run("pre_clr", "00", "00", "00");
    div_load = 1'b1; div_value = 8'd12;
    run("ld12", "0", "0", "1");
    div_load = 1'b0;
    run("ld12_wait", "000", "111", "111");
    sync_clr = 1'b1;
    run("sclr", "0", "0", "0");
    sync_clr = 1'b0;
    run("div12", "000000000001", "000001111110", "000000000000");

    // Load 1 together with sync_clr: applied immediately, tick follows en.
    div_load = 1'b1; div_value = 8'd1; sync_clr = 1'b1;
    run("ld1_clr", "0", "0", "0");
    div_load = 1'b0; sync_clr = 1'b0;
    run("div1", "1111", "0000", "0000");
    en = 1'b0;
    run("div1_off", "0", "0", "0");
    en = 1'b1;
    run("div1_on", "1", "0", "0");

    // Load 0 while N=1: applied the cycle after capture, then all stopped.
    div_load = 1'b1; div_value = 8'd0;
    run("ld0", "1", "0", "1");
    div_load = 1'b0;
    run("div0", "10000", "00000", "00000");

    // Leave the stopped state with N=6, run to count=3 with a load pending,
    // then reset: everything clears and the divisor returns to 8.
    div_load = 1'b1; div_value = 8'd6;
    run("ld6", "0", "0", "1");
    div_load = 1'b0;
    run("div6", "000", "000", "000");
    div_load = 1'b1; div_value = 8'd5;
    run("ld5_r", "0", "1", "1");
    div_load = 1'b0;
    reset = 1'b1;
    run("rst2", "0", "0", "0");
    reset = 1'b0;
    run("post_rst", "00000001", "00011110", "00000000");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
